// File: rtl/pic_8259_pkg.sv
// Shared 8259 definitions: sequencer states, OCW2 command codes and
// ICW1/ICW4/OCW3 bit positions used by the sequencer, priority resolver and in-service logic.
package pic_8259_pkg;

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    READY     = 3'd1,
    WAIT_ICW2 = 3'd2,
    WAIT_ICW3 = 3'd3,
    WAIT_ICW4 = 3'd4
  } seq_state_e;

  // OCW2 R/SL/EOI field (bits 7:5)
  localparam logic [2:0] OCW2_ROT_AEOI_CLR  = 3'b000;
  localparam logic [2:0] OCW2_NONSPEC_EOI   = 3'b001;
  localparam logic [2:0] OCW2_NOP           = 3'b010;
  localparam logic [2:0] OCW2_SPEC_EOI      = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET  = 3'b100;
  localparam logic [2:0] OCW2_ROT_NONSPEC   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIORITY  = 3'b110;
  localparam logic [2:0] OCW2_ROT_SPEC      = 3'b111;

  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW1_SNGL_BIT = 1;
  localparam int ICW1_IC4_BIT  = 0;

  localparam int ICW4_SFNM_BIT = 4;
  localparam int ICW4_BUF_BIT  = 3;
  localparam int ICW4_MS_BIT   = 2;
  localparam int ICW4_AEOI_BIT = 1;

  localparam int OCW3_ESMM_BIT = 6;
  localparam int OCW3_SMM_BIT  = 5;
  localparam int OCW3_P_BIT    = 2;
  localparam int OCW3_RR_BIT   = 1;
  localparam int OCW3_RIS_BIT  = 0;

endpackage

// File: rtl/strobe_edge_detector.sv
// One-flop history on a write strobe; rise_o is high while the strobe is
// high now but was low at the previous clock edge.
module strobe_edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= strobe_i;
  end

  assign rise_o = strobe_i & ~prev_q;

endmodule

// File: rtl/pic_command_sequencer.sv
// 8259 ICW initialization sequencer, configuration/mask registers and OCW2/OCW3 command pulses.
// Optional macro PIC_AEOI_ROTATE_EN adds the auto_rotate_mode output (OCW2 codes 100/000).
module pic_command_sequencer
  import pic_8259_pkg::*;
#(
  parameter logic [7:0] RESET_MASK    = 8'hFF,
  parameter int         INIT_REQUIRED = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_2,
  input  logic       write_operation_control_word_3,
  output logic       initialization_busy,
  output logic       level_or_edge_triggered,
  output logic       single_or_cascade,
  output logic [4:0] interrupt_vector_base,
  output logic [7:0] cascade_config,
  output logic       auto_eoi,
  output logic       buffered_mode,
  output logic       buffered_master,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       special_mask_mode,
  output logic       read_isr_select,
  output logic       poll_command,
  output logic       eoi_pulse,
  output logic       eoi_specific,
  output logic       rotate_on_eoi,
  output logic       set_priority_pulse,
  output logic [2:0] command_level,
`ifdef PIC_AEOI_ROTATE_EN
  output logic       auto_rotate_mode,
`endif
  output logic [2:0] debug_state
);

  logic icw1_edge, icw24_edge, ocw1_edge, ocw2_edge, ocw3_edge;

  strobe_edge_detector u_icw1  (.clock(clock), .reset_n(reset_n), .strobe_i(write_initial_command_word_1),   .rise_o(icw1_edge));
  strobe_edge_detector u_icw24 (.clock(clock), .reset_n(reset_n), .strobe_i(write_initial_command_word_2_4), .rise_o(icw24_edge));
  strobe_edge_detector u_ocw1  (.clock(clock), .reset_n(reset_n), .strobe_i(write_operation_control_word_1), .rise_o(ocw1_edge));
  strobe_edge_detector u_ocw2  (.clock(clock), .reset_n(reset_n), .strobe_i(write_operation_control_word_2), .rise_o(ocw2_edge));
  strobe_edge_detector u_ocw3  (.clock(clock), .reset_n(reset_n), .strobe_i(write_operation_control_word_3), .rise_o(ocw3_edge));

  seq_state_e state_q;
  logic       ltim_q, sngl_q, ic4_q;
  logic [4:0] vector_base_q;
  logic [7:0] cascade_q;
  logic       aeoi_q, buf_q, ms_q, sfnm_q;
  logic [7:0] mask_q;
  logic       smm_q, ris_q;
  logic       poll_q, eoi_q, eoi_spec_q, rot_q, setpri_q;
  logic [2:0] level_q;
`ifdef PIC_AEOI_ROTATE_EN
  logic       auto_rot_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (INIT_REQUIRED != 0) state_q <= UNINIT;
      else                    state_q <= READY;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      vector_base_q <= 5'd0;
      cascade_q     <= 8'd0;
      aeoi_q        <= 1'b0;
      buf_q         <= 1'b0;
      ms_q          <= 1'b0;
      sfnm_q        <= 1'b0;
      mask_q        <= RESET_MASK;
      smm_q         <= 1'b0;
      ris_q         <= 1'b0;
      poll_q        <= 1'b0;
      eoi_q         <= 1'b0;
      eoi_spec_q    <= 1'b0;
      rot_q         <= 1'b0;
      setpri_q      <= 1'b0;
      level_q       <= 3'd0;
`ifdef PIC_AEOI_ROTATE_EN
      auto_rot_q    <= 1'b0;
`endif
    end else begin
      // Pulses and their qualifiers last exactly one cycle unless re-armed below.
      poll_q     <= 1'b0;
      eoi_q      <= 1'b0;
      eoi_spec_q <= 1'b0;
      rot_q      <= 1'b0;
      setpri_q   <= 1'b0;
      level_q    <= 3'd0;
      if (icw1_edge) begin
        state_q <= WAIT_ICW2;
        ltim_q  <= internal_data_bus[ICW1_LTIM_BIT];
        sngl_q  <= internal_data_bus[ICW1_SNGL_BIT];
        ic4_q   <= internal_data_bus[ICW1_IC4_BIT];
        mask_q  <= 8'h00;
        smm_q   <= 1'b0;
        ris_q   <= 1'b0;
`ifdef PIC_AEOI_ROTATE_EN
        auto_rot_q <= 1'b0;
`endif
        if (!internal_data_bus[ICW1_IC4_BIT]) begin
          aeoi_q <= 1'b0;
          buf_q  <= 1'b0;
          ms_q   <= 1'b0;
          sfnm_q <= 1'b0;
        end
      end else begin
        case (state_q)
          WAIT_ICW2: if (icw24_edge) begin
            vector_base_q <= internal_data_bus[7:3];
            if (!sngl_q)    state_q <= WAIT_ICW3;
            else if (ic4_q) state_q <= WAIT_ICW4;
            else            state_q <= READY;
          end
          WAIT_ICW3: if (icw24_edge) begin
            cascade_q <= internal_data_bus;
            state_q   <= ic4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (icw24_edge) begin
            sfnm_q  <= internal_data_bus[ICW4_SFNM_BIT];
            buf_q   <= internal_data_bus[ICW4_BUF_BIT];
            ms_q    <= internal_data_bus[ICW4_MS_BIT];
            aeoi_q  <= internal_data_bus[ICW4_AEOI_BIT];
            state_q <= READY;
          end
          READY: begin
            if (ocw1_edge) mask_q <= internal_data_bus;
            if (ocw2_edge) begin
              case (internal_data_bus[7:5])
                OCW2_NONSPEC_EOI, OCW2_SPEC_EOI, OCW2_ROT_NONSPEC, OCW2_ROT_SPEC: begin
                  eoi_q      <= 1'b1;
                  eoi_spec_q <= internal_data_bus[6];
                  rot_q      <= internal_data_bus[7];
                  level_q    <= internal_data_bus[2:0];
                end
                OCW2_SET_PRIORITY: begin
                  setpri_q <= 1'b1;
                  level_q  <= internal_data_bus[2:0];
                end
`ifdef PIC_AEOI_ROTATE_EN
                OCW2_ROT_AEOI_SET: auto_rot_q <= 1'b1;
                OCW2_ROT_AEOI_CLR: auto_rot_q <= 1'b0;
`endif
                default: ;
              endcase
            end
            if (ocw3_edge) begin
              if (internal_data_bus[OCW3_ESMM_BIT]) smm_q <= internal_data_bus[OCW3_SMM_BIT];
              if (internal_data_bus[OCW3_RR_BIT])   ris_q <= internal_data_bus[OCW3_RIS_BIT];
              poll_q <= internal_data_bus[OCW3_P_BIT];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign initialization_busy     = (state_q == WAIT_ICW2) || (state_q == WAIT_ICW3) || (state_q == WAIT_ICW4);
  assign level_or_edge_triggered = ltim_q;
  assign single_or_cascade       = sngl_q;
  assign interrupt_vector_base   = vector_base_q;
  assign cascade_config          = cascade_q;
  assign auto_eoi                = aeoi_q;
  assign buffered_mode           = buf_q;
  assign buffered_master         = ms_q;
  assign special_fully_nested    = sfnm_q;
  assign interrupt_mask          = mask_q;
  assign special_mask_mode       = smm_q;
  assign read_isr_select         = ris_q;
  assign poll_command            = poll_q;
  assign eoi_pulse               = eoi_q;
  assign eoi_specific            = eoi_spec_q;
  assign rotate_on_eoi           = rot_q;
  assign set_priority_pulse      = setpri_q;
  assign command_level           = level_q;
`ifdef PIC_AEOI_ROTATE_EN
  assign auto_rotate_mode        = auto_rot_q;
`endif
  assign debug_state             = state_q;

endmodule

// File: doc/pic_command_sequencer.md
Name: pic_command_sequencer

Overview:
- Sits directly downstream of the 8259 read/write block and consumes its internal data bus and decoded write strobes.
- Sequences the ICW1→ICW2→(ICW3)→(ICW4) initialization and holds the ICW configuration registers and the OCW1 mask.
- Turns OCW2 and OCW3 writes into registered command pulses and mode bits for the priority resolver and in-service logic.

Parameters:
- RESET_MASK, 8'hFF, interrupt mask value after reset (all IRs masked).
- INIT_REQUIRED, 1, when 1, OCW writes are ignored until the first complete ICW sequence; when 0, OCWs are accepted straight after reset.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- internal_data_bus  in  8  latched write data.
- write_initial_command_word_1  in  1  ICW1 strobe, level, one or more cycles.
- write_initial_command_word_2_4  in  1  A0=1 write strobe, ICW2/3/4 candidate.
- write_operation_control_word_1  in  1  A0=1 write strobe, OCW1 candidate.
- write_operation_control_word_2  in  1  OCW2 strobe.
- write_operation_control_word_3  in  1  OCW3 strobe.
- initialization_busy  out  1  high while in any WAIT_ICWn state.
- level_or_edge_triggered  out  1  ICW1 LTIM.
- single_or_cascade  out  1  ICW1 SNGL.
- interrupt_vector_base  out  5  ICW2[7:3].
- cascade_config  out  8  ICW3 byte.
- auto_eoi  out  1  ICW4 AEOI.
- buffered_mode  out  1  ICW4 BUF.
- buffered_master  out  1  ICW4 M/S.
- special_fully_nested  out  1  ICW4 SFNM.
- interrupt_mask  out  8  OCW1 mask.
- special_mask_mode  out  1  OCW3 SMM.
- read_isr_select  out  1  1 = ISR, 0 = IRR.
- poll_command  out  1  one-cycle pulse.
- eoi_pulse  out  1  one-cycle pulse.
- eoi_specific  out  1  qualifies eoi_pulse.
- rotate_on_eoi  out  1  qualifies eoi_pulse.
- set_priority_pulse  out  1  one-cycle pulse.
- command_level  out  3  OCW2[2:0], valid with any OCW2 pulse.

Behaviour:
- Strobe handling:
  - Each strobe passes through a one-flop history.
  - An action occurs only on a sampled rising edge (high now, low at the previous edge); holding a strobe high never repeats the action.
  - internal_data_bus is sampled at that same edge.
  - Register outputs update at that edge; pulses are high for exactly the following cycle.
- Reset (async, any time, including mid-sequence):
  - State is READY, or UNINIT if INIT_REQUIRED=1.
  - interrupt_mask=RESET_MASK.
  - All other outputs 0.
  - History flops are cleared.
- States: UNINIT, READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
- ICW1 edge, from any state, overrides all simultaneous strobes:
  - Go to WAIT_ICW2 and latch LTIM, SNGL, IC4.
  - interrupt_mask=8'h00, special_mask_mode=0, read_isr_select=0.
  - Cancel any pulse scheduled for the next cycle.
  - If IC4=0, clear all ICW4 outputs.
- WAIT_ICW2 + ICW2_4 edge: latch the vector base.
  - SNGL=0 → WAIT_ICW3.
  - SNGL=1 and IC4=1 → WAIT_ICW4.
  - Otherwise → READY.
- WAIT_ICW3 + edge: latch cascade_config; IC4 ? WAIT_ICW4 : READY.
- WAIT_ICW4 + edge: latch bit4 SFNM, bit3 BUF, bit2 M/S, bit1 AEOI; → READY.
- The OCW1 strobe co-asserts with ICW2_4 (same A0=1 decode):
  - In a WAIT state, the ICW meaning wins and the mask is untouched.
  - In READY, load interrupt_mask.
  - In UNINIT, ignore.
- OCW2/OCW3 edges are ignored in UNINIT and WAIT states.
- OCW2 in READY, decoded on R/SL/EOI = bits 7:5:
  - 001: eoi_pulse.
  - 011: eoi_pulse with eoi_specific.
  - 101: eoi_pulse with rotate_on_eoi.
  - 111: eoi_pulse with eoi_specific and rotate_on_eoi.
  - 110: set_priority_pulse.
  - 010: no operation.
  - 100 and 000: see Optional Feature.
- OCW3 in READY:
  - ESMM=1 (bit6) loads special_mask_mode from SMM (bit5).
  - RR=1 (bit1) loads read_isr_select from RIS (bit0).
  - P=1 (bit2) pulses poll_command.
- Qualifier outputs eoi_specific, rotate_on_eoi and command_level are 0 whenever no pulse is active.

Optional Feature:
- Macro PIC_AEOI_ROTATE_EN.
- Defined:
  - Adds output auto_rotate_mode (1 bit), reset 0, cleared by ICW1.
  - OCW2 code 100 sets it; OCW2 code 000 clears it.
- Undefined:
  - Port absent.
  - Codes 100 and 000 are no-ops with no state change.

Decomposition:
- Package pic_8259_pkg holds:
  - Sequencer state enum.
  - OCW2 command code constants.
  - ICW1/ICW4/OCW3 bit-position constants.
  - Shared by the priority resolver and in-service blocks.
- Sub-module strobe_edge_detector:
  - One instance per strobe.
  - Flop plus AND-NOT.
  - Uses the same clock/reset_n.

Test Plan:
- Reset with INIT_REQUIRED=1 → state UNINIT, interrupt_mask=8'hFF; OCW1 with 8'h0F → mask stays 8'hFF.
- ICW1=8'h13, ICW2=8'h20, ICW4=8'h03 → skips WAIT_ICW3; vector_base=5'h04, auto_eoi=1, busy low after the ICW4 edge.
- ICW1=8'h11, ICW2=8'h40, ICW3=8'h04, ICW4=8'h01 → cascade_config=8'h04; then OCW1=8'hA5 → mask=8'hA5.
- READY, OCW2=8'h63 → one-cycle eoi_pulse with eoi_specific=1, command_level=3; strobe held 5 cycles → exactly one pulse.
- OCW3=8'h6B → special_mask_mode=1, read_isr_select=1, no poll; OCW3=8'h0C → poll_command pulse, other bits unchanged.
- ICW1 mid-sequence in WAIT_ICW3 → WAIT_ICW2, mask=8'h00; reset_n low between clock edges → outputs reset immediately.
